imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered immediate-generation stage for the RV32/RV64 decode path. It is the parametrised successor to the combinational immediate extender and sits between fetch/IF-ID and the ID register-read stage. It takes a raw 32-bit instruction on a valid/ready handshake and emits the sign- or zero-extended XLEN immediate, an immediate-type tag and the instruction, one cycle later. A 2-entry skid buffer gives full throughput under backpressure, and a flush input supports branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64, anything else is an elaboration error.
- EN_ZIMM, 1, when 1, decode CSR-immediate zimm; when 0, those instructions return type NONE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops all buffered entries.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  in/out: out  1  stage can accept; equals !skid_valid.
- instr_i  in  32  raw instruction.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts.
- instr_o  out  32  instruction passthrough.
- imm_o  out  XLEN  extended immediate.
- imm_type_o  out  3  NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ZIMM=7.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - main_valid and skid_valid are 0.
  - out_valid_o=0, instr_o=0, imm_o=0, imm_type_o=NONE.
  - in_ready_o=1.
- Immediate decode by opcode Instr[6:0]:
  - 0000011, 1100111 → I type: sext(Instr[31:20]).
  - 0010011 → I type. Exception: when funct3 is 001 or 101, the result is SHAMT type: zext(Instr[24:20]) for XLEN=32, zext(Instr[25:20]) for XLEN=64.
  - 0100011 → S type: sext({Instr[31:25], Instr[11:7]}).
  - 1100011 → B type: sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
  - 1101111 → J type: sext({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}).
  - 0110111, 0010111 → U type: sext({Instr[31:12], 12'b0}). For XLEN=64, bit 31 is replicated upward.
  - 1110011 with funct3[2]=1 and EN_ZIMM=1 → ZIMM type: zext(Instr[19:15]).
  - Everything else → imm=0, type NONE. The instruction is still passed through with valid.
- Latency: exactly 1 cycle from an accepted input beat to out_valid_o, when the output register is empty or draining.
- Handshake:
  - An input beat is accepted when in_valid_i && in_ready_o.
  - An output beat is consumed when out_valid_o && out_ready_i.
  - Outputs hold stable while out_valid_o && !out_ready_i.
- Skid buffer:
  - The main register drives the outputs.
  - If an input beat is accepted while main is valid and not consumed, the decoded beat goes to the skid register.
  - On a consume, skid moves to main if skid is valid; otherwise the new input (if any) loads main.
  - in_ready_o = !skid_valid, so it is purely registered with no combinational path from out_ready_i.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Simultaneous accept and consume with skid empty: main is replaced by the new beat, and occupancy is unchanged.
- Full condition (both entries valid): in_ready_o=0. The cycle after a consume, skid moves to main and in_ready_o returns to 1.
- flush_i:
  - Next edge clears main_valid and skid_valid.
  - It has priority over a same-cycle accept: that beat is discarded.
  - Data registers are not cleared.
- Reset mid-operation: all in-flight beats are lost, and outputs return to reset values asynchronously.

Decomposition:
- Package imm_gen_pkg:
  - imm_type_e enum (3-bit, encodings above).
  - Opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM.
  - Function3 constants for shifts.
- Sub-module imm_decode: purely combinational, parametrised by XLEN and EN_ZIMM; instr in, imm and type out. It is instantiated once, on the input side of both registers. The skid/pipe control logic lives in imm_gen_pipe.

Test Plan:
- XLEN=32, instr 0x123450B7 (lui x1,0x12345), out_ready=1 → next cycle out_valid=1, imm=0x12345000, type=U.
- XLEN=64:
  - 0xFFF00093 (addi x1,x0,-1) → imm=0xFFFFFFFFFFFFFFFF, type=I.
  - 0x4030D093 (srai x1,x1,3) → imm=0x3, type=SHAMT.
- XLEN=32, 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, type=B. Also 0x0000000F (fence) → imm=0, type=NONE, valid=1.
- Stream 5 back-to-back beats with out_ready=0 for 3 cycles after the first beat:
  - in_ready falls after 2 accepts.
  - All 5 beats emerge in order with no loss.
  - Outputs stay stable while stalled.
- Both entries full, then flush_i=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle beat never appears.
- Deassert rst_n mid-stream with out_valid=1 → out_valid=0 and imm=0 immediately, without waiting for a clock. After release, the first beat appears 1 cycle after accept.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate-type encodings and RISC-V opcode constants
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32/RV64 immediate extraction and typing
import imm_gen_pkg::*;

module imm_decode #(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o
);

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [5:0]         w_shamt;
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [20:0] w_imm_j;
    logic signed [31:0] w_imm_u;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    // RV32 shifts only own a 5-bit shamt; bit 25 belongs to funct7 there
    assign w_shamt  = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};
    assign w_imm_i  = instr_i[31:20];
    assign w_imm_s  = {instr_i[31:25], instr_i[11:7]};
    assign w_imm_b  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign w_imm_u  = {instr_i[31:12], 12'b0};

    // signed temporaries make the width casts below sign-extend
    always_comb begin
        imm_o  = '0;
        type_o = IMM_NONE;
        case (w_opcode)
            OP_LOAD, OP_JALR: begin
                imm_o  = XLEN'(w_imm_i);
                type_o = IMM_I;
            end
            OP_IMM: begin
                if (w_funct3 == F3_SLL || w_funct3 == F3_SRX) begin
                    imm_o  = XLEN'(w_shamt);
                    type_o = IMM_SHAMT;
                end else begin
                    imm_o  = XLEN'(w_imm_i);
                    type_o = IMM_I;
                end
            end
            OP_STORE: begin
                imm_o  = XLEN'(w_imm_s);
                type_o = IMM_S;
            end
            OP_BRANCH: begin
                imm_o  = XLEN'(w_imm_b);
                type_o = IMM_B;
            end
            OP_JAL: begin
                imm_o  = XLEN'(w_imm_j);
                type_o = IMM_J;
            end
            OP_LUI, OP_AUIPC: begin
                imm_o  = XLEN'(w_imm_u);
                type_o = IMM_U;
            end
            OP_SYSTEM: begin
                if (EN_ZIMM && w_funct3[2]) begin
                    imm_o  = XLEN'(instr_i[19:15]);
                    type_o = IMM_ZIMM;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
import imm_gen_pkg::*;

module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] w_dec_imm;
    imm_type_e       w_dec_type;
    logic            w_accept;
    logic            w_consume;

    logic            r_main_valid;
    logic [31:0]     r_main_instr;
    logic [XLEN-1:0] r_main_imm;
    imm_type_e       r_main_type;
    logic            r_skid_valid;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_imm;
    imm_type_e       r_skid_type;

    imm_decode #(
        .XLEN    (XLEN),
        .EN_ZIMM (EN_ZIMM)
    ) u_decode (
        .instr_i (instr_i),
        .imm_o   (w_dec_imm),
        .type_o  (w_dec_type)
    );

    assign w_accept  = in_valid_i && !r_skid_valid;
    assign w_consume = r_main_valid && out_ready_i;

    // skid can only fill while main is valid, so main empty implies skid empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_instr <= '0;
            r_main_imm   <= '0;
            r_main_type  <= IMM_NONE;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_imm   <= '0;
            r_skid_type  <= IMM_NONE;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_instr <= r_skid_instr;
                r_main_imm   <= r_skid_imm;
                r_main_type  <= r_skid_type;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_instr <= instr_i;
                    r_main_imm   <= w_dec_imm;
                    r_main_type  <= w_dec_type;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= instr_i;
            r_skid_imm   <= w_dec_imm;
            r_skid_type  <= w_dec_type;
        end
    end

    assign in_ready_o  = !r_skid_valid;
    assign out_valid_o = r_main_valid;
    assign instr_o     = r_main_instr;
    assign imm_o       = r_main_imm;
    assign imm_type_o  = r_main_type;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN 32 and 64)
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    logic        in_ready32, out_valid32;
    logic [31:0] instr_o32;
    logic [31:0] imm32;
    logic [2:0]  type32;
    logic        in_ready64, out_valid64;
    logic [31:0] instr_o64;
    logic [63:0] imm64;
    logic [2:0]  type64;

    int total = 0;
    int bad   = 0;

    imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1'b1)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready32),
        .instr_i     (instr),
        .out_valid_o (out_valid32),
        .out_ready_i (out_ready),
        .instr_o     (instr_o32),
        .imm_o       (imm32),
        .imm_type_o  (type32)
    );

    imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1'b1)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready64),
        .instr_i     (instr),
        .out_valid_o (out_valid64),
        .out_ready_i (out_ready),
        .instr_o     (instr_o64),
        .imm_o       (imm64),
        .imm_type_o  (type64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_instr [10];
    logic [31:0] v_imm32 [10];
    logic [2:0]  v_t32   [10];
    logic [63:0] v_imm64 [10];
    logic [2:0]  v_t64   [10];

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          nrecv;
        logic        acc;
        logic        stall_prev;
        logic [31:0] held;

        v_instr = '{32'h123450B7, 32'hFFF00093, 32'h4030D093, 32'hFE000EE3, 32'h0000000F,
                    32'hFE512C23, 32'h001000EF, 32'h3408D073, 32'h02109093, 32'h800000B7};
        v_imm32 = '{32'h12345000, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFC, 32'h0,
                    32'hFFFFFFF8, 32'h800, 32'h11, 32'h1, 32'h80000000};
        v_t32   = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd6, 3'd4};
        v_imm64 = '{64'h12345000, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'hFFFFFFFFFFFFFFFC, 64'h0,
                    64'hFFFFFFFFFFFFFFF8, 64'h800, 64'h11, 64'h21, 64'hFFFFFFFF80000000};
        v_t64   = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd6, 3'd4};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        #12;
        check_val("rst_valid", out_valid32, 0);
        check_val("rst_instr", instr_o32, 0);
        check_val("rst_imm", imm32, 0);
        check_val("rst_type", type32, 0);
        check_val("rst_ready", in_ready32, 1);
        check_val("rst_imm64", imm64, 0);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr = v_instr[i]; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            check_val($sformatf("vec%0d_valid", i), out_valid32, 1);
            check_val($sformatf("vec%0d_instr", i), instr_o32, v_instr[i]);
            check_val($sformatf("vec%0d_imm32", i), imm32, v_imm32[i]);
            check_val($sformatf("vec%0d_type32", i), type32, v_t32[i]);
            check_val($sformatf("vec%0d_imm64", i), imm64, v_imm64[i]);
            check_val($sformatf("vec%0d_type64", i), type64, v_t64[i]);
        end
        step();
        check_val("drain_valid", out_valid32, 0);

        idx = 0; nrecv = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && nrecv < 5; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            in_valid  = (idx < 5);
            instr     = (idx < 5) ? (32'((idx + 1) << 20) | 32'h93) : 32'h0;
            acc = in_valid && in_ready32;
            if (stall_prev)
                check_val("strm_hold", instr_o32, held);
            if (cyc == 2) begin
                check_val("strm_rdy_low", in_ready32, 0);
                check_val("strm_accepts", idx, 2);
            end
            if (out_valid32 && out_ready) begin
                check_val("strm_order", instr_o32, 32'((nrecv + 1) << 20) | 32'h93);
                check_val("strm_imm", imm32, 32'(nrecv + 1));
                nrecv++;
            end
            stall_prev = out_valid32 && !out_ready;
            held = instr_o32;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check_val("strm_count", nrecv, 5);
        step();
        check_val("strm_empty", out_valid32, 0);

        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00A00093;
        step();
        instr = 32'h00B00093;
        step();
        check_val("full_ready", in_ready32, 0);
        check_val("full_head", instr_o32, 32'h00A00093);
        flush = 1'b1; instr = 32'h00C00093;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_valid", out_valid32, 0);
        check_val("flush_ready", in_ready32, 1);
        in_valid = 1'b1; instr = 32'h00D00093;
        step();
        check_val("pre_flush_valid", out_valid32, 1);
        flush = 1'b1; instr = 32'h00E00093;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_val("flush_prio_valid", out_valid32, 0);
        check_val("flush_prio_ready", in_ready32, 1);
        step();
        check_val("flushed_gone", out_valid32, 0);

        in_valid = 1'b1; instr = 32'h123450B7; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_val("mid_valid", out_valid32, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid32, 0);
        check_val("arst_imm", imm32, 0);
        check_val("arst_type", type32, 0);
        check_val("arst_imm64", imm64, 0);
        #2 rst_n = 1'b1;
        step();
        check_val("post_rst_idle", out_valid32, 0);
        in_valid = 1'b1; instr = 32'hFE000EE3; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_val("post_rst_valid", out_valid32, 1);
        check_val("post_rst_imm", imm32, 32'hFFFFFFFC);
        step();
        check_val("post_rst_drain", out_valid32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
